// File: rtl/id_decode_queue_pkg.sv
// Shared decode constants: opcodes, instruction field positions
// and opcode-class helpers for the buffered decode stage.
package id_decode_queue_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_SLTIU   = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LW      = 6'h23;

   localparam logic [4:0] REG_RA = 5'd31;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 26;
   localparam int RS_HI  = 25;
   localparam int RS_LO  = 21;
   localparam int RT_HI  = 20;
   localparam int RT_LO  = 16;
   localparam int RD_HI  = 15;
   localparam int RD_LO  = 11;
   localparam int SH_HI  = 10;
   localparam int SH_LO  = 6;
   localparam int FN_HI  = 5;
   localparam int FN_LO  = 0;
   localparam int IMM_HI = 15;
   localparam int TGT_HI = 25;

   typedef enum logic [1:0] {
      FMT_NOP,
      FMT_R,
      FMT_I,
      FMT_J
   } fmt_e;

   function automatic fmt_e op_fmt(input logic [5:0] op);
      case (op)
         OP_SPECIAL:    return FMT_R;
         OP_J, OP_JAL:  return FMT_J;
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
         OP_LW:         return FMT_I;
         default:       return FMT_NOP;
      endcase
   endfunction

   function automatic logic imm_zext(input logic [5:0] op);
      return op inside {OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
   endfunction

endpackage

// File: rtl/id_inst_fifo.sv
// Instruction queue: power-of-two FIFO with wrap-bit pointers,
// synchronous clear and a combinational head view.
module id_inst_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PW = $clog2(DEPTH) + 1;

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                    (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
   assign head    = mem[rd_ptr[PW-2:0]];
   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PW-2:0]] <= din;
   end

endmodule

// File: rtl/id_decode_queue.sv
// Buffered decode stage: queues fetched instructions, decodes the
// head, holds on load-use hazards and redirects on jumps.
module id_decode_queue
   import id_decode_queue_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int REG_ADDR_W  = 5,
   parameter int QUEUE_DEPTH = 4,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ADDR_W-1:0]      in_addr,
   input  logic [DATA_W-1:0]      in_inst,
   output logic                   reg_read_en_1,
   output logic                   reg_read_en_2,
   output logic [REG_ADDR_W-1:0]  reg_addr_1,
   output logic [REG_ADDR_W-1:0]  reg_addr_2,
   input  logic [DATA_W-1:0]      reg_val_mux_data_1,
   input  logic [DATA_W-1:0]      reg_val_mux_data_2,
   input  logic                   ex_load_pending,
   input  logic [REG_ADDR_W-1:0]  ex_load_dest,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ADDR_W-1:0]      out_addr,
   output logic [5:0]             funct,
   output logic [DATA_W-1:0]      operand_1,
   output logic [DATA_W-1:0]      operand_2,
   output logic [4:0]             shamt,
   output logic                   write_reg_en,
   output logic [REG_ADDR_W-1:0]  write_reg_addr,
   output logic                   branch_redirect,
   output logic [ADDR_W-1:0]      branch_target,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   localparam int ENT_W = ADDR_W + DATA_W;

   logic                  fifo_push, fifo_pop, fifo_clear;
   logic                  fifo_full, fifo_empty;
   logic [ENT_W-1:0]      fifo_head;
   logic [ADDR_W-1:0]     head_addr;
   logic [DATA_W-1:0]     head_inst;
   logic [5:0]            opcode;
   logic [REG_ADDR_W-1:0] rs, rt, rd;
   logic [15:0]           imm;
   fmt_e                  fmt;
   logic                  need_1, need_2, is_jump, hazard, issue;
   logic [5:0]            d_funct;
   logic [DATA_W-1:0]     d_op1, d_op2;
   logic [4:0]            d_shamt;
   logic                  d_wen;
   logic [REG_ADDR_W-1:0] d_waddr;
   logic [ADDR_W-1:0]     d_target;

   id_inst_fifo #(
      .DEPTH (QUEUE_DEPTH),
      .WIDTH (ENT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .clear (fifo_clear),
      .din   ({in_addr, in_inst}),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   assign head_addr = fifo_head[ENT_W-1:DATA_W];
   assign head_inst = fifo_head[DATA_W-1:0];
   assign opcode    = head_inst[OPC_HI:OPC_LO];
   assign rs        = REG_ADDR_W'(head_inst[RS_HI:RS_LO]);
   assign rt        = REG_ADDR_W'(head_inst[RT_HI:RT_LO]);
   assign rd        = REG_ADDR_W'(head_inst[RD_HI:RD_LO]);
   assign imm       = head_inst[IMM_HI:0];
   assign fmt       = fifo_empty ? FMT_NOP : op_fmt(opcode);
   assign d_target  = ADDR_W'({head_addr[ADDR_W-1 -: 4],
                               head_inst[TGT_HI:0], 2'b00});

   assign reg_read_en_1 = need_1 && (rs != '0);
   assign reg_read_en_2 = need_2 && (rt != '0);
   assign reg_addr_1    = need_1 ? rs : '0;
   assign reg_addr_2    = need_2 ? rt : '0;

   always_comb begin
      need_1  = 1'b0;
      need_2  = 1'b0;
      is_jump = 1'b0;
      d_funct = '0;
      d_op1   = '0;
      d_op2   = '0;
      d_shamt = '0;
      d_wen   = 1'b0;
      d_waddr = '0;
      unique case (fmt)
         FMT_R: begin
            need_1  = 1'b1;
            need_2  = 1'b1;
            d_funct = head_inst[FN_HI:FN_LO];
            d_op1   = reg_read_en_1 ? reg_val_mux_data_1 : '0;
            d_op2   = reg_read_en_2 ? reg_val_mux_data_2 : '0;
            d_shamt = head_inst[SH_HI:SH_LO];
            d_wen   = 1'b1;
            d_waddr = rd;
         end
         FMT_I: begin
            need_1  = 1'b1;
            d_funct = opcode;
            d_op1   = reg_read_en_1 ? reg_val_mux_data_1 : '0;
            d_op2   = imm_zext(opcode) ? DATA_W'(imm)
                                       : DATA_W'($signed(imm));
            d_wen   = 1'b1;
            d_waddr = rt;
         end
         FMT_J: begin
            is_jump = 1'b1;
            d_funct = opcode;
            if (opcode == OP_JAL) begin
               d_op1   = DATA_W'(head_addr + ADDR_W'(8));
               d_wen   = 1'b1;
               d_waddr = REG_ADDR_W'(REG_RA);
            end
         end
         default: ;
      endcase
   end

   assign hazard = ex_load_pending && (ex_load_dest != '0) &&
                   ((reg_read_en_1 && rs == ex_load_dest) ||
                    (reg_read_en_2 && rt == ex_load_dest));
   assign issue  = !fifo_empty && !hazard && !flush &&
                   (!out_valid || out_ready);

   // A jump squashes everything fetched behind it, including this cycle's push.
   assign fifo_clear = flush || (issue && is_jump);
   assign fifo_pop   = issue;
   assign in_ready   = !fifo_full && !rst;
   assign fifo_push  = in_valid && in_ready && !fifo_clear;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid       <= 1'b0;
         out_addr        <= '0;
         funct           <= '0;
         operand_1       <= '0;
         operand_2       <= '0;
         shamt           <= '0;
         write_reg_en    <= 1'b0;
         write_reg_addr  <= '0;
         branch_redirect <= 1'b0;
         branch_target   <= '0;
      end else if (flush) begin
         out_valid       <= 1'b0;
         branch_redirect <= 1'b0;
      end else if (issue) begin
         out_valid       <= 1'b1;
         out_addr        <= head_addr;
         funct           <= d_funct;
         operand_1       <= d_op1;
         operand_2       <= d_op2;
         shamt           <= d_shamt;
         write_reg_en    <= d_wen;
         write_reg_addr  <= d_waddr;
         branch_redirect <= is_jump;
         branch_target   <= is_jump ? d_target : '0;
      end else begin
         branch_redirect <= 1'b0;
         if (out_ready) out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (hazard && stall_cnt != '1) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_id_decode_queue.sv
// Directed self-checking bench for id_decode_queue.
module tb_id_decode_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_addr;
   logic [31:0] in_inst;
   logic        reg_read_en_1, reg_read_en_2;
   logic [4:0]  reg_addr_1, reg_addr_2;
   logic [31:0] reg_val_mux_data_1, reg_val_mux_data_2;
   logic        ex_load_pending;
   logic [4:0]  ex_load_dest;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_addr;
   logic [5:0]  funct;
   logic [31:0] operand_1, operand_2;
   logic [4:0]  shamt;
   logic        write_reg_en;
   logic [4:0]  write_reg_addr;
   logic        branch_redirect;
   logic [31:0] branch_target;
   logic [15:0] stall_cnt;

   int passed = 0;
   int total  = 0;

   localparam logic [31:0] V1 = 32'hAAAA_0001;
   localparam logic [31:0] V2 = 32'hBBBB_0002;

   id_decode_queue dut (
      .clk                (clk),
      .rst                (rst),
      .flush              (flush),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .in_addr            (in_addr),
      .in_inst            (in_inst),
      .reg_read_en_1      (reg_read_en_1),
      .reg_read_en_2      (reg_read_en_2),
      .reg_addr_1         (reg_addr_1),
      .reg_addr_2         (reg_addr_2),
      .reg_val_mux_data_1 (reg_val_mux_data_1),
      .reg_val_mux_data_2 (reg_val_mux_data_2),
      .ex_load_pending    (ex_load_pending),
      .ex_load_dest       (ex_load_dest),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .out_addr           (out_addr),
      .funct              (funct),
      .operand_1          (operand_1),
      .operand_2          (operand_2),
      .shamt              (shamt),
      .write_reg_en       (write_reg_en),
      .write_reg_addr     (write_reg_addr),
      .branch_redirect    (branch_redirect),
      .branch_target      (branch_target),
      .stall_cnt          (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] addu(input logic [4:0] s,
                                        input logic [4:0] t,
                                        input logic [4:0] d);
      return {6'h00, s, t, d, 5'd0, 6'h21};
   endfunction

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      in_valid = 1'b0;
      in_addr = '0;
      in_inst = '0;
      reg_val_mux_data_1 = V1;
      reg_val_mux_data_2 = V2;
      ex_load_pending = 1'b0;
      ex_load_dest = '0;
      out_ready = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      step();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_stall", stall_cnt, 0);
      chk("rst_rd_en", reg_read_en_1, 0);

      // 1) single ADDU
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_addr = 32'h100;
      in_inst = addu(5'd1, 5'd2, 5'd3);
      step();
      in_valid = 1'b0;
      chk("t1_head_ra1", {reg_read_en_1, reg_addr_1}, {1'b1, 5'd1});
      chk("t1_head_ra2", {reg_read_en_2, reg_addr_2}, {1'b1, 5'd2});
      chk("t1_no_out_yet", out_valid, 0);
      step();
      chk("t1_out_valid", out_valid, 1);
      chk("t1_out_addr", out_addr, 32'h100);
      chk("t1_wr", {write_reg_en, write_reg_addr}, {1'b1, 5'd3});
      chk("t1_funct", funct, 6'h21);
      chk("t1_ops", {operand_1, operand_2}, {V1, V2});
      step();
      chk("t1_drain", out_valid, 0);

      // I-types and unknown opcode
      in_valid = 1'b1;
      in_addr = 32'h180;
      in_inst = 32'h2405_FFFC;
      step();
      in_addr = 32'h184;
      in_inst = 32'h3426_8000;
      step();
      chk("addiu_op2", operand_2, 32'hFFFF_FFFC);
      chk("addiu_op1", operand_1, 0);
      chk("addiu_wr", write_reg_addr, 5'd5);
      in_addr = 32'h188;
      in_inst = 32'hFC00_0000;
      step();
      in_valid = 1'b0;
      chk("ori_ops", {operand_1, operand_2}, {V1, 32'h0000_8000});
      chk("ori_wr", write_reg_addr, 5'd6);
      step();
      chk("nop_valid", out_valid, 1);
      chk("nop_addr", out_addr, 32'h188);
      chk("nop_wen", write_reg_en, 0);
      chk("nop_ops", {operand_1, operand_2}, 64'd0);
      step();
      chk("nop_drain", out_valid, 0);

      // 2) backpressure and ordering
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_addr = 32'h200 + 32'(4 * i);
         in_inst = addu(5'd1, 5'd2, 5'(i + 4));
         step();
      end
      chk("t2_full", in_ready, 0);
      chk("t2_hold0", out_addr, 32'h200);
      in_addr = 32'h214;
      in_inst = addu(5'd1, 5'd2, 5'd9);
      step();
      step();
      chk("t2_still_full", in_ready, 0);
      chk("t2_hold_addr", {out_valid, out_addr}, {1'b1, 32'h200});
      out_ready = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk("t2_order", {out_valid, out_addr},
             {1'b1, 32'h200 + 32'(4 * k)});
         if (k == 2) in_valid = 1'b0;
      end
      chk("t2_last_wr", write_reg_addr, 5'd9);
      step();
      chk("t2_drain", out_valid, 0);

      // 3) load-use hazard
      ex_load_pending = 1'b1;
      ex_load_dest = 5'd1;
      in_valid = 1'b1;
      in_addr = 32'h300;
      in_inst = addu(5'd1, 5'd2, 5'd3);
      step();
      in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("t3_bubble", out_valid, 0);
      end
      chk("t3_stall", stall_cnt, 3);
      ex_load_pending = 1'b0;
      step();
      chk("t3_issue", {out_valid, out_addr}, {1'b1, 32'h300});
      step();

      // 4) JAL redirect squashes queued entries and same-cycle push
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_addr = 32'h400;
      in_inst = addu(5'd1, 5'd2, 5'd3);
      step();
      in_addr = 32'h1000;
      in_inst = 32'h0C00_0040;
      step();
      in_addr = 32'h1004;
      in_inst = addu(5'd1, 5'd2, 5'd4);
      step();
      in_addr = 32'h1008;
      in_inst = addu(5'd1, 5'd2, 5'd5);
      step();
      chk("t4_filler", {out_valid, out_addr}, {1'b1, 32'h400});
      out_ready = 1'b1;
      in_addr = 32'h500;
      in_inst = addu(5'd1, 5'd2, 5'd6);
      step();
      in_valid = 1'b0;
      chk("t4_redirect", branch_redirect, 1);
      chk("t4_target", branch_target, 32'h100);
      chk("t4_out", {out_valid, out_addr}, {1'b1, 32'h1000});
      chk("t4_ra", {write_reg_en, write_reg_addr}, {1'b1, 5'd31});
      chk("t4_link", operand_1, 32'h1008);
      chk("t4_q_empty", reg_read_en_1, 0);
      step();
      chk("t4_pulse_end", branch_redirect, 0);
      chk("t4_no_more", out_valid, 0);

      // 5) flush beats push and pop
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_addr = 32'h600 + 32'(4 * i);
         in_inst = addu(5'd1, 5'd2, 5'd7);
         step();
      end
      chk("t5_pre", {out_valid, reg_read_en_1}, {1'b1, 1'b1});
      flush = 1'b1;
      out_ready = 1'b1;
      in_addr = 32'h700;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("t5_out_clr", out_valid, 0);
      chk("t5_q_empty", {reg_read_en_1, in_ready}, {1'b0, 1'b1});
      step();
      chk("t5_dropped", out_valid, 0);
      chk("t5_stall_kept", stall_cnt, 3);

      // 6) async reset mid-stall, then saturation
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_addr = 32'h800;
      in_inst = addu(5'd1, 5'd2, 5'd3);
      step();
      in_addr = 32'h804;
      step();
      in_valid = 1'b0;
      ex_load_pending = 1'b1;
      ex_load_dest = 5'd1;
      step();
      step();
      chk("t6_pre_stall", stall_cnt, 5);
      chk("t6_pre_out", out_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_out", {out_valid, out_addr}, 33'd0);
      chk("t6_rst_bundle", {write_reg_en, write_reg_addr, operand_1}, 38'd0);
      chk("t6_rst_stall", stall_cnt, 0);
      chk("t6_rst_q", reg_read_en_1, 0);
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_addr = 32'h900;
      step();
      in_valid = 1'b0;
      repeat (10) step();
      chk("t6_cnt10", stall_cnt, 10);
      chk("t6_bubble", out_valid, 0);
      repeat (65530) step();
      chk("t6_sat", stall_cnt, 16'hFFFF);
      step();
      chk("t6_sat_hold", stall_cnt, 16'hFFFF);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
